// File: rtl/alu_vector_capture.sv
// Capture buffer for ALU test vectors: records {srca, srcb, alucontrol, aluout, zero}
// words while capturing, then streams them out in capture order over valid/ready.
module alu_vector_capture #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       cap_valid,
    input  logic [WIDTH-1:0]           srca,
    input  logic [WIDTH-1:0]           srcb,
    input  logic [2:0]                 alucontrol,
    input  logic [WIDTH-1:0]           aluout,
    input  logic                       zero,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [3*WIDTH+3:0]         rd_data,
    output logic                       rd_last,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       capturing,
    output logic                       full,
    output logic                       overflow,
    output logic                       done
);

    localparam int DW = 3*WIDTH + 4;
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;
    logic            wr_en;
    logic [PW-1:0]   wr_addr;
    logic [DW-1:0]   wr_word;
    logic [DW-1:0]   mem [DEPTH];

    assign wr_word = {srca, srcb, alucontrol, aluout, zero};

    // NOTE: combinational next-state logic uses blocking assignments and gives every
    // output a default first, so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = count_q[PW-1:0];
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CAPTURE;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    rd_ptr_d   = '0;
                end
            end
            CAPTURE: begin
                if (start) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                    rd_ptr_d   = '0;
                end
                // The write is evaluated against the post-restart count so a
                // start+cap_valid cycle lands in mem[0].
                if (cap_valid) begin
                    if (count_d < CW'(DEPTH)) begin
                        wr_en   = 1'b1;
                        wr_addr = count_d[PW-1:0];
                        count_d = count_d + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (!start && stop) begin
                    rd_ptr_d = '0;
                    if (count_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (start) begin
                    state_d    = CAPTURE;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    rd_ptr_d   = '0;
                end else if (rd_ready) begin
                    if (rd_last) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the storage array has no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= wr_word;
        end
    end

    assign rd_valid  = (state_q == DRAIN);
    assign rd_last   = rd_valid && (CW'(rd_ptr_q) == count_q - CW'(1));
    assign rd_data   = rd_valid ? mem[rd_ptr_q] : '0;
    assign count     = count_q;
    assign capturing = (state_q == CAPTURE);
    assign full      = (count_q == CW'(DEPTH));
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_vector_capture.sv
// Randomized and directed bench for alu_vector_capture: a queue-based reference model
// predicts status every cycle and feeds a scoreboard checked by a separate monitor.
module tb_alu_vector_capture;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 3*WIDTH + 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset, start, stop, cap_valid, zero, rd_ready;
    logic [WIDTH-1:0]  srca, srcb, aluout;
    logic [2:0]        alucontrol;
    logic              rd_valid, rd_last, capturing, full, overflow, done;
    logic [DW-1:0]     rd_data;
    logic [CW-1:0]     count;

    int checks   = 0;
    int failures = 0;

    typedef enum {M_IDLE, M_CAP, M_DRAIN} mode_t;
    typedef struct {
        logic [DW-1:0] word;
        logic          last;
    } exp_t;

    mode_t          mode;
    logic [DW-1:0]  buf_q[$];
    exp_t           exp_q[$];
    int             drained;
    bit             ovf_m;
    bit             done_m;

    always #5 clk = ~clk;

    alu_vector_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .cap_valid(cap_valid),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .aluout(aluout), .zero(zero),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .count(count), .capturing(capturing), .full(full), .overflow(overflow), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a plain queue of words; one call per clock edge.
    task automatic model_step();
        logic [DW-1:0] w;
        w = {srca, srcb, alucontrol, aluout, zero};
        done_m = 1'b0;
        if (reset) begin
            mode = M_IDLE;
            buf_q.delete();
            exp_q.delete();
            ovf_m = 1'b0;
            drained = 0;
        end else begin
            case (mode)
                M_IDLE: if (start) begin
                    buf_q.delete();
                    ovf_m = 1'b0;
                    mode = M_CAP;
                end
                M_CAP: begin
                    if (start) begin
                        buf_q.delete();
                        ovf_m = 1'b0;
                    end
                    if (cap_valid) begin
                        if (buf_q.size() < DEPTH) buf_q.push_back(w);
                        else ovf_m = 1'b1;
                    end
                    if (!start && stop) begin
                        if (buf_q.size() == 0) begin
                            mode = M_IDLE;
                            done_m = 1'b1;
                        end else begin
                            mode = M_DRAIN;
                            drained = 0;
                            foreach (buf_q[i]) exp_q.push_back('{buf_q[i], i == buf_q.size() - 1});
                        end
                    end
                end
                M_DRAIN: begin
                    if (start) begin
                        buf_q.delete();
                        exp_q.delete();
                        ovf_m = 1'b0;
                        mode = M_CAP;
                    end else if (rd_ready) begin
                        drained++;
                        if (drained == buf_q.size()) begin
                            mode = M_IDLE;
                            done_m = 1'b1;
                        end
                    end
                end
                default: mode = M_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(buf_q.size()));
        check("full", 32'(full), 32'(buf_q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("capturing", 32'(capturing), 32'(mode == M_CAP));
        check("rd_valid", 32'(rd_valid), 32'(mode == M_DRAIN));
        check("done", 32'(done), 32'(done_m));
        if (mode != M_DRAIN) begin
            check("rd_data_idle", 32'(rd_data), 32'h0);
            check("rd_last_idle", 32'(rd_last), 32'h0);
        end
        start = 1'b0;
        stop = 1'b0;
        cap_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic set_fields(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c,
                              input logic [3:0] o, input logic z);
        srca = a; srcb = b; alucontrol = c; aluout = o; zero = z;
    endtask

    task automatic rand_fields();
        set_fields(4'($urandom), 4'($urandom), 3'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_valid = 1'b1;
            rand_fields();
            tick();
        end
    endtask

    task automatic drain_all();
        rd_ready = 1'b1;
        for (int k = 0; k < 40 && mode == M_DRAIN; k++) tick();
        rd_ready = 1'b0;
        tick();
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        logic [DW-1:0] held;
        bit            stalled;
        exp_t          e;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (stalled) check("stall_hold", 32'(rd_data), 32'(held));
                if (rd_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_read", 32'(rd_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", 32'(rd_data), 32'(e.word));
                        check("rd_last", 32'(rd_last), 32'(e.last));
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = rd_data;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;
        set_fields(4'h0, 4'h0, 3'h0, 4'h0, 1'b0);
        mode = M_IDLE; ovf_m = 1'b0; done_m = 1'b0; drained = 0;
        reset = 1'b1; tick();
        reset = 1'b1; tick();

        // Single capture and drain: expects 16'h5350.
        start = 1'b1; tick();
        cap_valid = 1'b1; set_fields(4'b0101, 4'b0011, 3'b010, 4'b1000, 1'b0); tick();
        stop = 1'b1; tick();
        drain_all();

        // Ordering: 5350, F1DC, 33C1.
        start = 1'b1; tick();
        cap_valid = 1'b1; set_fields(4'b0101, 4'b0011, 3'b010, 4'b1000, 1'b0); tick();
        cap_valid = 1'b1; set_fields(4'b1111, 4'b0001, 3'b110, 4'b1110, 1'b0); tick();
        cap_valid = 1'b1; set_fields(4'b0011, 4'b0011, 3'b110, 4'b0000, 1'b1); tick();
        stop = 1'b1; tick();
        drain_all();

        // Full and overflow.
        start = 1'b1; tick();
        capture(6);
        stop = 1'b1; tick();
        drain_all();

        // Backpressure: stall for three cycles mid-drain.
        start = 1'b1; tick();
        capture(3);
        stop = 1'b1; tick();
        rd_ready = 1'b1; tick();
        rd_ready = 1'b0; tick(); tick(); tick();
        drain_all();

        // Edge events: stop with empty buffer; cap_valid with stop.
        start = 1'b1; tick();
        stop = 1'b1; tick();
        tick();
        start = 1'b1; tick();
        stop = 1'b1; cap_valid = 1'b1; rand_fields(); tick();
        drain_all();

        // Restart during capture with same-cycle write.
        start = 1'b1; tick();
        capture(2);
        start = 1'b1; cap_valid = 1'b1; rand_fields(); tick();
        stop = 1'b1; tick();
        drain_all();

        // Abort drain with start; reset during capture at count=3.
        start = 1'b1; tick();
        capture(2);
        stop = 1'b1; tick();
        tick();
        start = 1'b1; tick();
        capture(3);
        reset = 1'b1; tick();
        tick();

        // Randomized sessions.
        for (int t = 0; t < 60; t++) begin
            start = 1'b1; tick();
            for (int i = $urandom_range(0, 7); i > 0; i--) begin
                cap_valid = 1'($urandom_range(0, 1));
                rand_fields();
                if ($urandom_range(0, 9) == 0) start = 1'b1;
                if ($urandom_range(0, 19) == 0) reset = 1'b1;
                tick();
            end
            stop = 1'b1; cap_valid = 1'($urandom_range(0, 1)); rand_fields(); tick();
            for (int k = 0; k < 60 && mode == M_DRAIN; k++) begin
                rd_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 29) == 0) begin
                    start = 1'b1;
                    rd_ready = 1'b0;
                end
                tick();
            end
            rd_ready = 1'b0;
            stop = 1'($urandom_range(0, 1)); cap_valid = 1'($urandom_range(0, 1)); rand_fields();
            tick();
        end

        reset = 1'b1; tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
